// File: rtl/branch_inflight_queue_if.sv
// branch_inflight_queue_if: fetch push, ALU resolve and predictor reconcile signals of the in-flight branch queue.
interface branch_inflight_queue_if #(
    parameter int DEPTH = 4,
    parameter int ADDRESS_WIDTH = 22,
    parameter int GHR_SIZE = 8
);
    logic i_Stall;
    logic i_push;
    logic [ADDRESS_WIDTH-1:0] i_push_pc;
    logic i_push_taken;
    logic [ADDRESS_WIDTH-1:0] i_push_alt_pc;
    logic i_resolve;
    logic i_resolve_taken;
    logic o_full;
    logic o_empty;
    logic [$clog2(DEPTH):0] o_count;
    logic o_isbranch_check;
    logic o_ALU_outcome;
    logic o_ALU_prediction;
    logic [GHR_SIZE-1:0] o_ALU_pc;
    logic o_mispredict;
    logic [ADDRESS_WIDTH-1:0] o_redirect_pc;
    logic o_overflow;
    logic o_underflow;

    modport master (
        output i_Stall, i_push, i_push_pc, i_push_taken, i_push_alt_pc, i_resolve, i_resolve_taken,
        input o_full, o_empty, o_count, o_isbranch_check, o_ALU_outcome, o_ALU_prediction, o_ALU_pc,
        o_mispredict, o_redirect_pc, o_overflow, o_underflow
    );
    modport slave (
        input i_Stall, i_push, i_push_pc, i_push_taken, i_push_alt_pc, i_resolve, i_resolve_taken,
        output o_full, o_empty, o_count, o_isbranch_check, o_ALU_outcome, o_ALU_prediction, o_ALU_pc,
        o_mispredict, o_redirect_pc, o_overflow, o_underflow
    );
endinterface

// File: rtl/branch_inflight_queue.sv
// branch_inflight_queue: FIFO of predicted branches; resolves the oldest, reports to the predictor and flushes on mispredict.
module branch_inflight_queue #(
    parameter int DEPTH = 4,
    parameter int ADDRESS_WIDTH = 22,
    parameter int GHR_SIZE = 8
) (
    input logic i_Clk,
    input logic i_Reset,
    branch_inflight_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [GHR_SIZE-1:0] pc_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] alt_mem [DEPTH];
    logic taken_mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic active, is_empty, is_full, do_res, mis, correct, push_ok;
    logic unused_pc_hi;

    // Only the PC slice is ever reported, so only that slice is stored.
    assign unused_pc_hi = ^bus.i_push_pc[ADDRESS_WIDTH-1:GHR_SIZE];

    always_comb begin
        active = ~bus.i_Stall;
        is_empty = count == '0;
        is_full = count == (PW+1)'(DEPTH);
        do_res = active & bus.i_resolve & ~is_empty;
        mis = do_res & (bus.i_resolve_taken != taken_mem[head]);
        correct = do_res & ~mis;
        push_ok = active & bus.i_push & ~mis & (~is_full | correct);
    end

    assign bus.o_full = is_full;
    assign bus.o_empty = is_empty;
    assign bus.o_count = count;

    always_ff @(posedge i_Clk) begin
        if (push_ok) begin
            pc_mem[tail] <= bus.i_push_pc[GHR_SIZE-1:0];
            taken_mem[tail] <= bus.i_push_taken;
            alt_mem[tail] <= bus.i_push_alt_pc;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            bus.o_isbranch_check <= 1'b0;
            bus.o_ALU_outcome <= 1'b0;
            bus.o_ALU_prediction <= 1'b0;
            bus.o_ALU_pc <= '0;
            bus.o_mispredict <= 1'b0;
            bus.o_redirect_pc <= '0;
            bus.o_overflow <= 1'b0;
            bus.o_underflow <= 1'b0;
        end else begin
            bus.o_isbranch_check <= do_res;
            bus.o_mispredict <= mis;
            if (do_res) begin
                bus.o_ALU_outcome <= bus.i_resolve_taken;
                bus.o_ALU_prediction <= taken_mem[head];
                bus.o_ALU_pc <= pc_mem[head];
            end
            if (mis) begin
                bus.o_redirect_pc <= alt_mem[head];
                head <= tail;
                count <= '0;
            end else begin
                head <= head + PW'(correct);
                tail <= tail + PW'(push_ok);
                count <= count + (PW+1)'(push_ok) - (PW+1)'(correct);
            end
            if (active & bus.i_push & ~mis & ~push_ok)
                bus.o_overflow <= 1'b1;
            if (active & bus.i_resolve & is_empty)
                bus.o_underflow <= 1'b1;
        end
    end
endmodule
